// File: rtl/match_log_reader.sv
// Read side of the sniffer match memory: tracks committed records,
// fetches them in write order and streams them out with backpressure.
module match_log_reader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              wr_inc,
  input  logic              clear,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              full,
  output logic              overflow,
  output logic [ADDR_W:0]   pending
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int FD    = RD_LAT + 2;
  localparam int FW    = $clog2(FD);
  localparam int CW    = $clog2(FD + 1);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   rd_ptr_q;
  logic [ADDR_W:0]     pend_q, pend_d;
  logic [CW-1:0]       infl_q, infl_d;
  logic [CW-1:0]       occ_q, occ_d;
  logic [CW-1:0]       fcnt_q;
  logic [RD_LAT-1:0]   vpipe_q, vpipe_d;
  logic [FW-1:0]       wp_q, rp_q;
  logic [DATA_W-1:0]   fifo_q [FD];
  logic                ovf_q;
  logic                issue, acc, ret, pop;

  function automatic logic [FW-1:0] nxt(input logic [FW-1:0] p);
    return (p == FW'(FD - 1)) ? '0 : p + 1'b1;
  endfunction

  // One slot beyond the read latency holds the head being taken,
  // so a read can issue every cycle while the host keeps up.
  assign issue = (state_q == STREAM) && (pend_q != '0) &&
                 (({1'b0, occ_q} + {1'b0, infl_q}) < (CW+1)'(FD));

  assign full      = (pend_q == (ADDR_W+1)'(DEPTH));
  assign acc       = wr_inc && !full && !clear;
  assign ret       = vpipe_q[RD_LAT-1];
  assign pop       = out_valid && out_ready;

  assign mem_rd_en = issue;
  assign mem_raddr = rd_ptr_q;
  assign out_valid = (occ_q != '0);
  assign out_data  = fifo_q[rp_q];
  assign overflow  = ovf_q;
  assign pending   = pend_q;

  always_comb begin
    pend_d  = pend_q + (ADDR_W+1)'(acc) - (ADDR_W+1)'(issue);
    infl_d  = infl_q + CW'(issue) - CW'(ret);
    occ_d   = occ_q + CW'(ret) - CW'(pop);
    vpipe_d = (vpipe_q << 1) | RD_LAT'(issue);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      pend_q   <= '0;
      infl_q   <= '0;
      occ_q    <= '0;
      fcnt_q   <= '0;
      vpipe_q  <= '0;
      wp_q     <= '0;
      rp_q     <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < FD; i++) fifo_q[i] <= '0;
    end else if (clear) begin
      state_q  <= FLUSH;
      rd_ptr_q <= '0;
      pend_q   <= '0;
      infl_q   <= '0;
      occ_q    <= '0;
      fcnt_q   <= '0;
      vpipe_q  <= '0;
      wp_q     <= '0;
      rp_q     <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_q + ADDR_W'(issue);
      pend_q   <= pend_d;
      infl_q   <= infl_d;
      occ_q    <= occ_d;
      vpipe_q  <= vpipe_d;
      if (ret) begin
        fifo_q[wp_q] <= mem_rdata;
        wp_q         <= nxt(wp_q);
      end
      if (pop) rp_q <= nxt(rp_q);
      if (wr_inc && full) ovf_q <= 1'b1;
      case (state_q)
        IDLE:
          if (acc) state_q <= STREAM;
        STREAM:
          if (pend_d == '0 && infl_d == '0 && occ_d == '0)
            state_q <= IDLE;
        FLUSH: begin
          fcnt_q <= fcnt_q + 1'b1;
          if (fcnt_q == CW'(RD_LAT - 1))
            state_q <= (pend_d != '0) ? STREAM : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_match_log_reader.sv
// Directed bench for match_log_reader: default instance plus a
// 4-deep instance for full/overflow/wrap, both scoreboarded.
module tb_match_log_reader;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;

  logic        wr0 = 0, clr0 = 0, rdy0 = 0;
  logic        rd0, v0, full0, ovf0;
  logic [7:0]  ad0;
  logic [31:0] rdata0, d0;
  logic [8:0]  pend0;

  logic        wr1 = 0, clr1 = 0, rdy1 = 0;
  logic        rd1, v1, full1, ovf1;
  logic [1:0]  ad1;
  logic [31:0] rdata1, d1;
  logic [2:0]  pend1;

  logic [31:0] m0a, m0b, m1a, m1b;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] e0, e1;
  int          vec = 0, miss = 0;
  int          wp0 = 0, wp1 = 0;

  always #5 clk = ~clk;

  match_log_reader u0 (
    .clk(clk), .n_rst(n_rst), .wr_inc(wr0), .clear(clr0),
    .mem_rd_en(rd0), .mem_raddr(ad0), .mem_rdata(rdata0),
    .out_valid(v0), .out_data(d0), .out_ready(rdy0),
    .full(full0), .overflow(ovf0), .pending(pend0)
  );

  match_log_reader #(.ADDR_W(2)) u1 (
    .clk(clk), .n_rst(n_rst), .wr_inc(wr1), .clear(clr1),
    .mem_rd_en(rd1), .mem_raddr(ad1), .mem_rdata(rdata1),
    .out_valid(v1), .out_data(d1), .out_ready(rdy1),
    .full(full1), .overflow(ovf1), .pending(pend1)
  );

  // record memories: data = address + 0x100, two-cycle read latency
  always @(posedge clk) begin
    m0a <= rd0 ? 32'h100 + 32'(ad0) : 32'hdeadbeef;
    m0b <= m0a;
    m1a <= rd1 ? 32'h100 + 32'(ad1) : 32'hdeadbeef;
    m1b <= m1a;
  end
  assign rdata0 = m0b;
  assign rdata1 = m1b;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (n_rst && v0 && rdy0) begin
      if (q0.size() == 0) begin
        vec++; miss++;
        $error("FAIL sb0_extra: observed %0h expected none", d0);
      end else begin
        e0 = q0.pop_front();
        chk("sb0_data", 64'(d0), 64'(e0));
      end
    end
    if (n_rst && v1 && rdy1) begin
      if (q1.size() == 0) begin
        vec++; miss++;
        $error("FAIL sb1_extra: observed %0h expected none", d1);
      end else begin
        e1 = q1.pop_front();
        chk("sb1_data", 64'(d1), 64'(e1));
      end
    end
  end

  task automatic push0();
    q0.push_back(32'h100 + 32'(wp0));
    wp0 = (wp0 + 1) % 256;
  endtask

  task automatic push1();
    q1.push_back(32'h100 + 32'(wp1));
    wp1 = (wp1 + 1) % 4;
  endtask

  task automatic chk_rst0(input string tag);
    chk({tag, "_rd_en"}, 64'(rd0), 64'(0));
    chk({tag, "_raddr"}, 64'(ad0), 64'(0));
    chk({tag, "_valid"}, 64'(v0), 64'(0));
    chk({tag, "_data"}, 64'(d0), 64'(0));
    chk({tag, "_full"}, 64'(full0), 64'(0));
    chk({tag, "_ovf"}, 64'(ovf0), 64'(0));
    chk({tag, "_pend"}, 64'(pend0), 64'(0));
  endtask

  task automatic do_reset();
    n_rst = 0;
    wr0 = 0; clr0 = 0; rdy0 = 0;
    wr1 = 0; clr1 = 0; rdy1 = 0;
    @(posedge clk); #1;
    chk_rst0("rst");
    chk("rst_u1_pend", 64'(pend1), 64'(0));
    chk("rst_u1_ovf", 64'(ovf1), 64'(0));
    @(posedge clk); #1;
    n_rst = 1;
    q0.delete(); q1.delete();
    wp0 = 0; wp1 = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int iss;
    int pm, ipm, ovm, last;
    bit acc1, saw_full, saw_wrap;

    // single record
    do_reset();
    for (int c = 0; c < 8; c++) begin
      wr0 = (c == 0); rdy0 = 1;
      if (wr0) push0();
      @(negedge clk);
      if (c == 0) chk("single_rd_c0", 64'(rd0), 64'(0));
      if (c == 1) begin
        chk("single_rd_c1", 64'(rd0), 64'(1));
        chk("single_addr_c1", 64'(ad0), 64'(0));
        chk("single_pend_c1", 64'(pend0), 64'(1));
      end
      if (c == 3 || c == 5) chk("single_valid_off", 64'(v0), 64'(0));
      if (c == 4) begin
        chk("single_valid_c4", 64'(v0), 64'(1));
        chk("single_data_c4", 64'(d0), 64'(32'h100));
      end
      if (c == 6) chk("single_idle", 64'(u0.state_q), 64'(0));
      @(posedge clk); #1;
    end
    chk("single_drained", 64'(q0.size()), 64'(0));

    // burst of ten
    do_reset();
    for (int c = 0; c < 16; c++) begin
      wr0 = (c < 10); rdy0 = 1;
      if (wr0) push0();
      @(negedge clk);
      if (c >= 4 && c <= 13) begin
        chk("burst_valid", 64'(v0), 64'(1));
        chk("burst_data", 64'(d0), 64'(32'h100 + 32'(c - 4)));
      end
      if (c == 14) chk("burst_end", 64'(v0), 64'(0));
      @(posedge clk); #1;
    end
    chk("burst_drained", 64'(q0.size()), 64'(0));

    // backpressure
    do_reset();
    iss = 0;
    for (int c = 0; c < 30; c++) begin
      wr0 = (c < 6); rdy0 = !(c >= 4 && c <= 12);
      if (wr0) push0();
      @(negedge clk);
      if (c <= 3 && rd0) iss++;
      if (c == 3) chk("bp_issued", 64'(iss), 64'(3));
      if (c >= 4 && c <= 12) begin
        chk("bp_hold_valid", 64'(v0), 64'(1));
        chk("bp_hold_data", 64'(d0), 64'(32'h100));
      end
      @(posedge clk); #1;
    end
    chk("bp_drained", 64'(q0.size()), 64'(0));

    // clear mid-stream
    do_reset();
    for (int c = 0; c < 15; c++) begin
      wr0 = (c <= 5); rdy0 = (c >= 5); clr0 = (c == 4);
      if (clr0) begin
        q0.delete(); wp0 = 0;
      end else if (wr0) push0();
      @(negedge clk);
      if (c == 4) chk("clr_pre_valid", 64'(v0), 64'(1));
      if (c >= 5 && c <= 9) chk("clr_valid_off", 64'(v0), 64'(0));
      if (c == 5 || c == 6) chk("clr_no_issue", 64'(rd0), 64'(0));
      if (c == 5) begin
        chk("clr_pend", 64'(pend0), 64'(0));
        chk("clr_ovf", 64'(ovf0), 64'(0));
      end
      if (c == 7) begin
        chk("clr_reissue", 64'(rd0), 64'(1));
        chk("clr_addr0", 64'(ad0), 64'(0));
      end
      if (c == 10) begin
        chk("clr_out_valid", 64'(v0), 64'(1));
        chk("clr_out_data", 64'(d0), 64'(32'h100));
      end
      @(posedge clk); #1;
    end
    clr0 = 0;
    chk("clr_drained", 64'(q0.size()), 64'(0));

    // async reset mid-burst
    do_reset();
    for (int c = 0; c < 6; c++) begin
      wr0 = 1; rdy0 = 1;
      push0();
      @(negedge clk);
      @(posedge clk); #1;
    end
    wr0 = 0;
    #2 n_rst = 0;
    #1 chk_rst0("arst");
    q0.delete();
    repeat (2) @(posedge clk);
    #1 n_rst = 1;
    wp0 = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("arst_no_valid", 64'(v0), 64'(0));
      chk("arst_no_issue", 64'(rd0), 64'(0));
      @(posedge clk); #1;
    end

    // wrap / full / overflow on the 4-deep instance
    do_reset();
    pm = 0; ipm = 0; ovm = 0; last = -1;
    saw_full = 0; saw_wrap = 0;
    for (int c = 0; c < 40; c++) begin
      wr1 = (c < 9); rdy1 = (c >= 20);
      acc1 = wr1 && (pm != 4);
      if (acc1) push1();
      @(negedge clk);
      chk("wrap_pend", 64'(pend1), 64'(pm));
      chk("wrap_full", 64'(full1), 64'(pm == 4));
      chk("wrap_ovf", 64'(ovf1), 64'(ovm));
      if (pm == 4) saw_full = 1;
      if (rd1) begin
        chk("wrap_addr", 64'(ad1), 64'(ipm));
        if (ipm == 0 && last == 3) saw_wrap = 1;
        last = ipm;
        ipm = (ipm + 1) % 4;
      end
      if (wr1 && pm == 4) ovm = 1;
      pm = pm + int'(acc1) - int'(rd1);
      @(posedge clk); #1;
    end
    chk("wrap_reached_full", 64'(saw_full), 64'(1));
    chk("wrap_ptr_wrapped", 64'(saw_wrap), 64'(1));
    chk("wrap_ovf_final", 64'(ovf1), 64'(1));
    chk("wrap_drained", 64'(q1.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
